// File: rtl/mem_access_ctrl.sv
// Single-word read/write handshake between the datapath and a synchronous RAM; owns MAR/MDR.
// Define MEM_BOUNDS_CHECK_EN to reject addresses >= MEM_DEPTH with err instead of touching the RAM.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 512
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    if (MEM_DEPTH > (64'd1 << ADDR_W)) begin : gen_depth_chk
        $error("MEM_DEPTH exceeds the address space");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              ram_read_q;
    logic              ram_write_q;
    logic              out_of_range;

`ifdef MEM_BOUNDS_CHECK_EN
    assign out_of_range = (32'(addr_in) >= MEM_DEPTH);
`else
    assign out_of_range = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= StIdle;
            mar_q       <= '0;
            mdr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mar_q  <= addr_in;
                        busy_q <= 1'b1;
                        if (out_of_range) begin
                            // Rejected request: skip the RAM entirely, MDR untouched.
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            if (rw) begin
                                mdr_q <= wdata;
                            end
                            ram_write_q <= rw;
                            ram_read_q  <= !rw;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                    if (ram_write_q) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        // RAM output is registered; data is valid one cycle later.
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    mdr_q   <= ram_rdata;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rdata     = mdr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = mar_q;
    assign ram_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 512x32 synchronous RAM attached.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic        rw;
    logic [8:0]  addr_in;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        ram_read;
    logic        ram_write;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_both = 0;
    int b_done, b_rd, b_wr, b_both;

    logic [31:0] mem [512];

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W(9),
        .DATA_W(32),
        .MEM_DEPTH(256)
    ) dut (
        .clk(clk),
        .clear(clear),
        .start(start),
        .rw(rw),
        .addr_in(addr_in),
        .wdata(wdata),
        .rdata(rdata),
        .busy(busy),
        .done(done),
        .err(err),
        .ram_read(ram_read),
        .ram_write(ram_write),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
        ram_rdata <= '0;
    end

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read) ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (ram_read === 1'b1) n_rd++;
        if (ram_write === 1'b1) n_wr++;
        if (ram_read === 1'b1 && ram_write === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_done = n_done;
        b_rd   = n_rd;
        b_wr   = n_wr;
        b_both = n_both;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_ram_read"}, 32'(ram_read), 32'h0);
        chk({tag, "_ram_write"}, 32'(ram_write), 32'h0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b0;
        rw = 1'b0;
        addr_in = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        clear = 1'b0;

        // Write 0xDEADBEEF to 0x005: done one cycle after accept.
        start = 1'b1; rw = 1'b1; addr_in = 9'h005; wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; wdata = '0;
        chk("wr_issue_ram_write", 32'(ram_write), 32'h1);
        chk("wr_issue_ram_read", 32'(ram_read), 32'h0);
        chk("wr_issue_addr", 32'(ram_addr), 32'h005);
        chk("wr_issue_wdata", ram_wdata, 32'hDEADBEEF);
        chk("wr_issue_busy", 32'(busy), 32'h1);
        chk("wr_issue_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("wr_done", 32'(done), 32'h1);
        chk("wr_done_ram_write", 32'(ram_write), 32'h0);
        chk("wr_done_err", 32'(err), 32'h0);
        chk("wr_mem5", mem[5], 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_idle_done", 32'(done), 32'h0);
        chk("wr_idle_busy", 32'(busy), 32'h0);
        chk("wr_rdata_mdr", rdata, 32'hDEADBEEF);

        // Read 0x000 first so the following read of 0x005 must change rdata.
        #1 snap();
        start = 1'b1; rw = 1'b0; addr_in = 9'h000;
        @(negedge clk);
        start = 1'b0;
        chk("rd0_issue_ram_read", 32'(ram_read), 32'h1);
        @(negedge clk);
        chk("rd0_capture_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("rd0_done", 32'(done), 32'h1);
        chk("rd0_rdata", rdata, init_word(0));
        @(negedge clk);
        #1;
        chk("rd0_read_cycles", 32'(n_rd - b_rd), 32'h1);
        chk("rd0_busy", 32'(busy), 32'h0);

        // Read 0x005 back: done two cycles after accept.
        start = 1'b1; rw = 1'b0; addr_in = 9'h005;
        @(negedge clk);
        start = 1'b0;
        chk("rd5_issue_ram_read", 32'(ram_read), 32'h1);
        chk("rd5_issue_ram_write", 32'(ram_write), 32'h0);
        chk("rd5_issue_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("rd5_capture_done", 32'(done), 32'h0);
        chk("rd5_capture_ram_read", 32'(ram_read), 32'h0);
        chk("rd5_capture_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("rd5_done", 32'(done), 32'h1);
        chk("rd5_rdata", rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd5_idle_busy", 32'(busy), 32'h0);

        // start every cycle, alternating rw: accepts at i=0 (write), 3 (read), 7 (read).
        #1 snap();
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            rw = (i % 2 == 0);
            addr_in = 9'(16 + i);
            wdata = 32'h10000000 + 32'(i);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("burst_done_count", 32'(n_done - b_done), 32'h3);
        chk("burst_write_cycles", 32'(n_wr - b_wr), 32'h1);
        chk("burst_read_cycles", 32'(n_rd - b_rd), 32'h2);
        chk("burst_overlap", 32'(n_both - b_both), 32'h0);
        chk("burst_mem10", mem[16], 32'h10000000);
        chk("burst_last_rdata", rdata, init_word(23));

        // clear lands on the edge closing ISSUE of a read.
        start = 1'b1; rw = 1'b0; addr_in = 9'h021;
        @(negedge clk);
        start = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_all_zero("midclr");
        #1 snap();
        repeat (3) @(negedge clk);
        #1;
        chk("midclr_no_done", 32'(n_done - b_done), 32'h0);
        start = 1'b1; rw = 1'b0; addr_in = 9'h022;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("postclr_done", 32'(done), 32'h1);
        chk("postclr_rdata", rdata, init_word(34));
        @(negedge clk);

        // clear beats start on the same edge.
        clear = 1'b1; start = 1'b1; rw = 1'b1; addr_in = 9'h003; wdata = 32'h55AA55AA;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        chk("clrprio_busy", 32'(busy), 32'h0);
        chk("clrprio_ram_write", 32'(ram_write), 32'h0);
        @(negedge clk);
        chk("clrprio_mem3", mem[3], init_word(3));
        chk("clrprio_rdata", rdata, 32'h0);

        // Address 0x1F0 against MEM_DEPTH = 256.
        #1 snap();
        start = 1'b1; rw = 1'b0; addr_in = 9'h1F0;
        @(negedge clk);
        start = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        chk("oor_done", 32'(done), 32'h1);
        chk("oor_err", 32'(err), 32'h1);
        chk("oor_ram_read", 32'(ram_read), 32'h0);
        chk("oor_rdata", rdata, 32'h0);
        @(negedge clk);
        chk("oor_idle_done", 32'(done), 32'h0);
        chk("oor_idle_err", 32'(err), 32'h0);
        chk("oor_idle_busy", 32'(busy), 32'h0);
        #1;
        chk("oor_no_strobe", 32'(n_rd + n_wr - b_rd - b_wr), 32'h0);
`else
        chk("far_ram_read", 32'(ram_read), 32'h1);
        @(negedge clk);
        chk("far_capture_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("far_done", 32'(done), 32'h1);
        chk("far_err", 32'(err), 32'h0);
        chk("far_rdata", rdata, init_word(496));
        @(negedge clk);
        chk("far_idle_busy", 32'(busy), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller between the CPU datapath's memory-transfer signals and the 512×32 synchronous RAM. It holds the MAR and MDR, runs a small handshake FSM for single-word reads and writes, and drives the RAM's Read, Write, AddressSignal and DataIn pins. It absorbs the RAM's one-cycle registered read latency, so the datapath sees a clean start/done handshake.

## Interface
- ADDR_W, 9, address width; must match the RAM AddressSignal width.
- DATA_W, 32, data word width.
- MEM_DEPTH, 512, number of implemented words; used only by the bounds check.
- clk  input  1  system clock; all state updates on posedge.
- clear  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- rw  input  1  0 = read, 1 = write; sampled with start.
- addr_in  input  ADDR_W  word address; latched into MAR on accept.
- wdata  input  DATA_W  write data; latched into MDR on accept.
- rdata  output  DATA_W  MDR contents (read result).
- busy  output  1  high from the accept edge until DONE ends.
- done  output  1  one-cycle completion pulse.
- err  output  1  out-of-range flag, valid while done = 1.
- ram_read  output  1  to RAM Read.
- ram_write  output  1  to RAM Write.
- ram_addr  output  ADDR_W  to RAM AddressSignal; always equals MAR.
- ram_wdata  output  DATA_W  to RAM DataIn; always equals MDR.
- ram_rdata  input  DATA_W  from RAM DataOut.

## Operation
- States: IDLE, ISSUE, CAPTURE, DONE. All outputs are registered.
- IDLE:
  - start = 1 at an edge: MAR <= addr_in, MDR <= wdata only if rw = 1, busy <= 1, go to ISSUE.
  - On that same edge, set ram_write <= rw and ram_read <= !rw.
- ISSUE (one cycle): the RAM performs the access at the closing edge.
  - Write: clear ram_write, go to DONE.
  - Read: clear ram_read, go to CAPTURE.
- CAPTURE (reads only): MDR <= ram_rdata at the closing edge, go to DONE.
- DONE: done = 1 for exactly one cycle, busy stays 1. Next state is IDLE with busy <= 0.
- start is ignored while busy = 1, including during DONE. There is no queuing. Issuing back-to-back requests costs one IDLE cycle between them.
- rdata holds the last read value until the next read's CAPTURE. Writes also update rdata, because MDR = wdata.
- ram_read and ram_write are never high together and never high outside ISSUE.

## Timing
- Accept edge E0:
  - Write: ISSUE during [E0,E1), RAM written at E1, done high during [E1,E2).
  - Read: ISSUE during [E0,E1), RAM DataOut valid after E1, MDR loaded at E2, done high during [E2,E3) with rdata valid.
- Latency from accept to done: write 1 cycle, read 2 cycles. Throughput is one access per 3 cycles (write) or 4 cycles (read).
- Reset: clear = 1 at an edge forces IDLE and sets MAR = 0, MDR = 0, rdata = 0, busy = 0, done = 0, err = 0, ram_read = 0, ram_write = 0, ram_addr = 0, ram_wdata = 0.
- Reset mid-operation:
  - If clear coincides with the edge closing ISSUE, the RAM still completes that access, because the RAM is not reset. The controller reports no done.
  - clear takes priority over start on the same edge.

## Configuration
- MEM_BOUNDS_CHECK_EN defined:
  - An accepted request with addr_in >= MEM_DEPTH goes IDLE -> DONE directly.
  - ram_read and ram_write stay 0, and MDR is unchanged.
  - err = 1 during that done cycle; err = 0 for all in-range accesses.
- MEM_BOUNDS_CHECK_EN undefined:
  - No range comparison is made; every address is issued to the RAM as-is.
  - err is tied to 0.

## Test plan
- Write 0xDEADBEEF to 0x005, then read 0x005: ram_write high one cycle with ram_addr = 0x005; done 1 cycle after accept. For the read, done 2 cycles after accept with rdata = 0xDEADBEEF.
- Read 0x000 after the RAM init file loads: rdata equals the RAM's word 0 at done; ram_read high for exactly one cycle.
- Pulse start every cycle for 10 cycles with alternating rw: exactly one access per handshake is accepted, none overlap, and ram_read/ram_write are never high together.
- Assert clear on the edge that closes ISSUE of a read: no done pulse follows, and all outputs read 0 the next cycle. A subsequent read completes normally.
- With MEM_BOUNDS_CHECK_EN and MEM_DEPTH = 256, read 0x1F0: done 1 cycle after accept, err = 1, no RAM strobe, rdata unchanged. Without the macro, the same request reads RAM[0x1F0] and err = 0.
